// File: rtl/ram_fifo_ctrl.sv
// Byte-stream FIFO controller for a single-port, registered-read RAM.
// One RAM access per cycle; a pending read always wins over an incoming write.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_pend;
  logic              rd_issue;
  logic              wr_fire;

  // Status flags derived from the RAM occupancy and the output pipeline.
  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0) && !rd_pend && !out_valid;
  end

  // Action decode: a read is issued whenever the output stage can absorb it,
  // and the input stalls in that cycle because the RAM port is taken.
  always_comb begin
    rd_issue = !reset && (count != '0) && !rd_pend && (!out_valid || out_ready);
    in_ready = !reset && !full && !rd_issue;
    wr_fire  = in_valid && in_ready;
  end

  // RAM port drive; idle cycles park the address on the write pointer.
  always_comb begin
    ram_wen  = wr_fire;
    ram_addr = rd_issue ? rd_ptr : wr_ptr;
    ram_din  = in_data;
  end

  // Pointers, occupancy and the one-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        count  <= count - CNT_W'(1);
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        count  <= count + CNT_W'(1);
      end

      // A read issued now returns data next cycle, so the pending flag lives one cycle.
      rd_pend <= rd_issue;

      if (rd_pend) begin
        out_data  <= ram_dout;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: queue-based reference model, behavioural RAM,
// and an in-order scoreboard of accepted bytes.
module tb_ram_fifo_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned VW    = 22;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ram_wen;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] mem [DEPTH];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: bytes held in RAM as a queue, one in-flight slot, one output slot.
  byte unsigned q_ram[$];
  byte unsigned sb[$];
  bit           m_pend;
  bit           m_ov;
  byte unsigned m_pd;
  byte unsigned m_od;
  int           m_wr_n;
  int           m_rd_n;
  bit           last_wr;

  logic [VW-1:0] obs;
  assign obs = {in_ready, ram_wen, ram_addr, out_valid, count, full, empty, out_data};

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic bit m_ri(input bit ordy);
    return (q_ram.size() != 0) && !m_pend && (!m_ov || ordy);
  endfunction

  function automatic bit m_ir(input bit ordy);
    return (q_ram.size() != DEPTH) && !m_ri(ordy);
  endfunction

  function automatic logic [VW-1:0] m_exp();
    bit         ri = m_ri(out_ready);
    bit         wr = in_valid && m_ir(out_ready);
    logic [3:0] a  = ri ? 4'(m_rd_n % 16) : 4'(m_wr_n % 16);
    bit         f  = (q_ram.size() == DEPTH);
    bit         e  = (q_ram.size() == 0) && !m_pend && !m_ov;
    return {m_ir(out_ready), wr, a, m_ov, 5'(q_ram.size()), f, e, 8'(m_od)};
  endfunction

  task automatic model_clock();
    bit ri;
    bit wr;
    last_wr = 1'b0;
    if (reset) begin
      q_ram.delete(); sb.delete();
      m_pend = 0; m_ov = 0; m_od = 0; m_wr_n = 0; m_rd_n = 0;
      return;
    end
    ri = m_ri(out_ready);
    wr = in_valid && m_ir(out_ready);
    if (m_pend) begin
      m_ov = 1; m_od = m_pd; m_pend = 0;
    end else if (m_ov && out_ready) begin
      m_ov = 0; void'(sb.pop_front());
    end
    if (ri) begin
      m_pd = q_ram.pop_front(); m_pend = 1; m_rd_n++;
    end
    if (wr) begin
      q_ram.push_back(in_data); sb.push_back(in_data); m_wr_n++;
    end
    last_wr = wr;
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
    repeat (2) begin
      #3;
      n_total++;
      if (ram_wen !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL reset_hold: wen/ready got %b%b want 00", ram_wen, in_ready);
      end
      advance();
    end
    reset = 1'b0;
    #3;
    n_total++;
    if (count !== 5'd0 || full !== 1'b0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL reset_flags: count=%0d full=%b empty=%b want 0 0 1", count, full, empty);
    end
    n_total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_out: valid=%b data=%h want 0 00", out_valid, out_data);
    end
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b0;
    advance();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    #3;
    n_total++;
    if (obs !== m_exp()) begin n_bad++; $display("FAIL single_c0: got %h want %h", obs, m_exp()); end
    n_total++;
    if (ram_wen !== 1'b1 || ram_addr !== 4'd0 || ram_din !== 8'h11) begin
      n_bad++; $display("FAIL single_write: wen=%b addr=%0d din=%h want 1 0 11", ram_wen, ram_addr, ram_din);
    end
    advance();
    in_valid = 1'b0;
    #3;
    n_total++;
    if (ram_wen !== 1'b0 || ram_addr !== 4'd0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_read: wen=%b addr=%0d ready=%b want 0 0 0", ram_wen, ram_addr, in_ready);
    end
    advance();
    #3;
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_c2: out_valid got %b want 0", out_valid); end
    advance();
    repeat (3) begin
      #3;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 8'h11) begin
        n_bad++; $display("FAIL single_hold: valid=%b data=%h want 1 11", out_valid, out_data);
      end
      advance();
    end
    out_ready = 1'b1;
    #3;
    n_total++;
    if (obs !== m_exp()) begin n_bad++; $display("FAIL single_pop: got %h want %h", obs, m_exp()); end
    advance();
    #3;
    n_total++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_empty: empty=%b valid=%b want 1 0", empty, out_valid);
    end
    out_ready = 1'b0;
    advance();
  endtask

  task automatic test_fill();
    byte unsigned b = 8'h00;
    int pops = 0;
    int acc_cyc = -1;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = b;
      #3;
      n_total++;
      if (obs !== m_exp()) begin n_bad++; $display("FAIL fill_cyc%0d: got %h want %h", i, obs, m_exp()); end
      advance();
      if (last_wr) b++;
    end
    #3;
    n_total++;
    if (count !== 5'd16 || full !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL fill_full: count=%0d full=%b ready=%b want 16 1 0", count, full, in_ready);
    end
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      n_bad++; $display("FAIL fill_head: valid=%b data=%h want 1 00", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!in_valid && q_ram.size() == 0 && !m_pend && !m_ov) break;
      #3;
      n_total++;
      if (obs !== m_exp()) begin n_bad++; $display("FAIL drain_cyc%0d: got %h want %h", i, obs, m_exp()); end
      if (in_valid && in_ready && acc_cyc < 0) acc_cyc = i;
      if (out_valid && out_ready) begin
        pops++;
        n_total++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          n_bad++; $display("FAIL fill_order: got %h want %h", out_data, (sb.size() != 0) ? sb[0] : 8'h00);
        end
      end
      advance();
      if (last_wr) in_valid = 1'b0;
    end
    #3;
    n_total++;
    if (acc_cyc != 1) begin n_bad++; $display("FAIL fill_late_accept: cycle %0d want 1", acc_cyc); end
    n_total++;
    if (pops != 18 || empty !== 1'b1) begin
      n_bad++; $display("FAIL fill_drain: pops=%0d empty=%b want 18 1", pops, empty);
    end
    advance();
  endtask

  task automatic test_wrap();
    int accepted = 0;
    int pops = 0;
    int lw = -1;
    int lr = -1;
    bit wr_wrap = 0;
    bit rd_wrap = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (accepted >= 40 && q_ram.size() == 0 && !m_pend && !m_ov) break;
      in_valid = (accepted < 40) && ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      #3;
      n_total++;
      if (obs !== m_exp()) begin n_bad++; $display("FAIL wrap_cyc%0d: got %h want %h", i, obs, m_exp()); end
      if (ram_wen) begin
        if (lw == 15 && ram_addr == 4'd0) wr_wrap = 1;
        lw = int'(ram_addr);
      end else if (!in_ready && !full) begin
        if (lr == 15 && ram_addr == 4'd0) rd_wrap = 1;
        lr = int'(ram_addr);
      end
      if (out_valid && out_ready) begin
        pops++;
        n_total++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          n_bad++; $display("FAIL wrap_order: got %h want %h", out_data, (sb.size() != 0) ? sb[0] : 8'h00);
        end
      end
      advance();
      if (last_wr) accepted++;
    end
    in_valid = 1'b0;
    #3;
    n_total++;
    if (wr_wrap != 1 || rd_wrap != 1) begin
      n_bad++; $display("FAIL wrap_ptr: wr_wrap=%0d rd_wrap=%0d want 1 1", wr_wrap, rd_wrap);
    end
    n_total++;
    if (pops != 40 || empty !== 1'b1) begin
      n_bad++; $display("FAIL wrap_count: pops=%0d empty=%b want 40 1", pops, empty);
    end
    advance();
  endtask

  task automatic test_collision();
    int pops = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    #3;
    n_total++;
    if (ram_wen !== 1'b1) begin n_bad++; $display("FAIL coll_first: wen got %b want 1", ram_wen); end
    advance();
    in_data = 8'hC3;
    #3;
    n_total++;
    if (ram_wen !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL coll_block: wen=%b ready=%b want 0 0", ram_wen, in_ready);
    end
    advance();
    #3;
    n_total++;
    if (ram_wen !== 1'b1 || ram_din !== 8'hC3) begin
      n_bad++; $display("FAIL coll_retry: wen=%b din=%h want 1 c3", ram_wen, ram_din);
    end
    advance();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q_ram.size() == 0 && !m_pend && !m_ov) break;
      #3;
      n_total++;
      if (obs !== m_exp()) begin n_bad++; $display("FAIL coll_cyc%0d: got %h want %h", i, obs, m_exp()); end
      if (out_valid && out_ready) begin
        pops++;
        n_total++;
        if (sb.size() == 0 || out_data !== sb[0]) begin
          n_bad++; $display("FAIL coll_order: got %h want %h", out_data, (sb.size() != 0) ? sb[0] : 8'h00);
        end
      end
      advance();
    end
    #3;
    n_total++;
    if (pops != 2 || empty !== 1'b1) begin
      n_bad++; $display("FAIL coll_count: pops=%0d empty=%b want 2 1", pops, empty);
    end
    advance();
  endtask

  task automatic test_mid_reset();
    int pushed = 0;
    int pops = 0;
    byte unsigned got[$];
    out_ready = 1'b0;
    for (int i = 0; i < 20 && pushed < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + pushed);
      #3;
      n_total++;
      if (obs !== m_exp()) begin n_bad++; $display("FAIL mr_push%0d: got %h want %h", i, obs, m_exp()); end
      advance();
      if (last_wr) pushed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && pops == 0; i++) begin
      #3;
      if (out_valid && out_ready) pops++;
      advance();
    end
    out_ready = 1'b0; reset = 1'b1;
    #3;
    advance();
    reset = 1'b0;
    #3;
    n_total++;
    if (count !== 5'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL mr_clear: count=%0d valid=%b empty=%b want 0 0 1", count, out_valid, empty);
    end
    out_ready = 1'b1; pushed = 0;
    for (int i = 0; i < 30; i++) begin
      if (pushed >= 2 && q_ram.size() == 0 && !m_pend && !m_ov) break;
      in_valid = (pushed < 2); in_data = 8'(8'hA0 + pushed);
      #3;
      n_total++;
      if (obs !== m_exp()) begin n_bad++; $display("FAIL mr_cyc%0d: got %h want %h", i, obs, m_exp()); end
      if (out_valid && out_ready) got.push_back(out_data);
      advance();
      if (last_wr) pushed++;
    end
    in_valid = 1'b0;
    n_total++;
    if (got.size() != 2) begin
      n_bad++; $display("FAIL mr_len: got %0d bytes want 2", got.size());
    end else begin
      n_total++;
      if (got[0] !== 8'hA0 || got[1] !== 8'hA1) begin
        n_bad++; $display("FAIL mr_data: got %h %h want a0 a1", got[0], got[1]);
      end
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
